// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the PC register and selects sequential, branch, jump,
// jump-register, stall, halt or exception-vector next PC. PC_DELAY_SLOT_EN enables delayed redirects.
module pc_sequencer #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'h80000180
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] startPC,
  input  logic        Stall,
  input  logic        Halt,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [15:0] BranchOffset,
  input  logic        Jump,
  input  logic [25:0] JumpTarget,
  input  logic        JumpReg,
  input  logic [31:0] RegTarget,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Valid,
  output logic        AddrErr,
  output logic        Halted
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               addr_err_q, addr_err_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic [31:0]        pc_plus4;
  logic [31:0]        br_tgt;
  logic [31:0]        j_tgt;
  logic [31:0]        tgt;
  logic               redirect;
`ifdef PC_DELAY_SLOT_EN
  logic               pend_q, pend_d;
  logic [31:0]        pend_tgt_q, pend_tgt_d;
`endif

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + {{14{BranchOffset[15]}}, BranchOffset, 2'b00};
  assign j_tgt    = {pc_plus4[31:28], JumpTarget, 2'b00};
  assign redirect = JumpReg | Jump | (Branch & Zero);
  assign tgt      = JumpReg ? RegTarget : (Jump ? j_tgt : br_tgt);

  // Next-state and next-PC selection
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    addr_err_d = 1'b0;
`ifdef PC_DELAY_SLOT_EN
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
`endif
    unique case (state_q)
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = ST_RUN;
        else                                  cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_RUN: begin
        if (Halt) begin
          state_d = ST_HALT;
`ifdef PC_DELAY_SLOT_EN
          pend_d  = 1'b0;
`endif
        end else if (Stall) begin
          pc_d = pc_q;
`ifdef PC_DELAY_SLOT_EN
        end else if (pend_q) begin
          pc_d   = pend_tgt_q;
          pend_d = 1'b0;
`endif
        end else if (redirect && (tgt[1:0] != 2'b00)) begin
          pc_d       = EXC_VECTOR;
          addr_err_d = 1'b1;
        end else if (redirect) begin
`ifdef PC_DELAY_SLOT_EN
          pc_d       = pc_plus4;
          pend_d     = 1'b1;
          pend_tgt_d = tgt;
`else
          pc_d       = tgt;
`endif
        end else begin
          pc_d = pc_plus4;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HOLD;
    endcase
    valid_d  = (state_d == ST_RUN);
    halted_d = (state_d == ST_HALT);
  end

  // Registers with synchronous reset overriding every state
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_HOLD;
      pc_q       <= startPC;
      cnt_q      <= '0;
      addr_err_q <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
`ifdef PC_DELAY_SLOT_EN
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      addr_err_q <= addr_err_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
`ifdef PC_DELAY_SLOT_EN
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
`endif
    end
  end

  assign PC      = pc_q;
  assign PCPlus4 = pc_plus4;
  assign Valid   = valid_q;
  assign AddrErr = addr_err_q;
  assign Halted  = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed boot/branch/jump/stall/halt steps, then random
// stimulus, all checked against a reference model of the next-PC rules.
module tb_pc_sequencer;

  localparam int unsigned HOLD = 2;
  localparam logic [31:0] EXC  = 32'h80000180;

  logic        Clock = 1'b0;
  logic        Reset, Stall, Halt, Branch, Zero, Jump, JumpReg;
  logic [31:0] startPC, RegTarget;
  logic [15:0] BranchOffset;
  logic [25:0] JumpTarget;
  logic [31:0] PC, PCPlus4;
  logic        Valid, AddrErr, Halted;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0=hold, 1=run, 2=halt
  int          m_mode, m_hold;
  logic [31:0] m_pc, m_ptgt;
  logic        m_pend, m_aerr;

  pc_sequencer #(.HOLD_CYCLES(HOLD), .EXC_VECTOR(EXC)) dut (
    .Clock(Clock), .Reset(Reset), .startPC(startPC), .Stall(Stall), .Halt(Halt),
    .Branch(Branch), .Zero(Zero), .BranchOffset(BranchOffset), .Jump(Jump),
    .JumpTarget(JumpTarget), .JumpReg(JumpReg), .RegTarget(RegTarget),
    .PC(PC), .PCPlus4(PCPlus4), .Valid(Valid), .AddrErr(AddrErr), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] pc4, t;
    logic        take;
    if (Reset) begin
      m_pc = startPC; m_mode = 0; m_hold = 0; m_pend = 1'b0; m_aerr = 1'b0;
      return;
    end
    m_aerr = 1'b0;
    if (m_mode == 0) begin
      m_hold++;
      if (m_hold >= HOLD) m_mode = 1;
    end else if (m_mode == 1) begin
      if (Halt) begin
        m_mode = 2; m_pend = 1'b0;
      end else if (Stall) begin
        m_pc = m_pc;
      end else if (m_pend) begin
        m_pc = m_ptgt; m_pend = 1'b0;
      end else begin
        pc4  = m_pc + 32'd4;
        take = 1'b1;
        t    = pc4;
        if (JumpReg)            t = RegTarget;
        else if (Jump)          t = {pc4[31:28], JumpTarget, 2'b00};
        else if (Branch && Zero) t = pc4 + 32'(int'($signed(BranchOffset)) * 4);
        else                    take = 1'b0;
        if (take && (t % 4 != 0)) begin
          m_pc = EXC; m_aerr = 1'b1;
        end else if (take) begin
`ifdef PC_DELAY_SLOT_EN
          m_pc = pc4; m_pend = 1'b1; m_ptgt = t;
`else
          m_pc = t;
`endif
        end else begin
          m_pc = pc4;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge Clock);
    model_edge();
    #1;
    check("pc",      PC,             m_pc);
    check("pcplus4", PCPlus4,        m_pc + 32'd4);
    check("valid",   32'(Valid),     32'(m_mode == 1));
    check("addrerr", 32'(AddrErr),   32'(m_aerr));
    check("halted",  32'(Halted),    32'(m_mode == 2));
  endtask

  task automatic idle();
    Stall = 0; Halt = 0; Branch = 0; Zero = 0; Jump = 0; JumpReg = 0;
  endtask

  task automatic jr_to(input logic [31:0] a);
    JumpReg = 1; RegTarget = a;
    step();
    JumpReg = 0;
`ifdef PC_DELAY_SLOT_EN
    step();
`endif
  endtask

  initial begin
    idle();
    Reset = 1; startPC = 32'h00400000; BranchOffset = '0; JumpTarget = '0; RegTarget = '0;
    m_mode = 0; m_hold = 0; m_pc = '0; m_ptgt = '0; m_pend = 0; m_aerr = 0;

    // Boot: two held cycles, then run from startPC
    step(); step();
    check("boot_pc", PC, 32'h00400000);
    Reset = 0;
    step();
    check("hold_valid", 32'(Valid), 32'd0);
    step();
    check("run_pc", PC, 32'h00400000);
    check("run_valid", 32'(Valid), 32'd1);
    step();
    check("seq1", PC, 32'h00400004);
    step();
    check("seq2", PC, 32'h00400008);

    // Backward branch taken / not taken
    jr_to(32'h00400010);
    check("jr_land", PC, 32'h00400010);
    Branch = 1; Zero = 1; BranchOffset = 16'hFFFC;
    step();
    Branch = 0; Zero = 0;
`ifdef PC_DELAY_SLOT_EN
    check("br_slot", PC, 32'h00400014);
    step();
`endif
    check("br_taken", PC, 32'h00400004);
    jr_to(32'h00400010);
    Branch = 1; Zero = 0;
    step();
    Branch = 0;
    check("br_not_taken", PC, 32'h00400014);

    // Jump, then jump-register beating jump
    jr_to(32'h0040001C);
    Jump = 1; JumpTarget = 26'h0100040;
    step();
    Jump = 0;
`ifdef PC_DELAY_SLOT_EN
    step();
`endif
    check("jump", PC, 32'h00400100);
    Jump = 1; JumpReg = 1; RegTarget = 32'h00400200;
    step();
    idle();
`ifdef PC_DELAY_SLOT_EN
    step();
`endif
    check("jr_over_j", PC, 32'h00400200);

    // Misaligned JR goes to the exception vector with a one-cycle AddrErr
    JumpReg = 1; RegTarget = 32'h00400102;
    step();
    JumpReg = 0;
    check("exc_pc", PC, EXC);
    check("exc_flag", 32'(AddrErr), 32'd1);
    step();
    check("exc_flag_clr", 32'(AddrErr), 32'd0);
    jr_to(32'h00400100);
    check("jr_aligned", PC, 32'h00400100);

    // Stall for three cycles, then resume
    jr_to(32'h00400020);
    Stall = 1;
    step(); step(); step();
    check("stall_pc", PC, 32'h00400020);
    Stall = 0;
    step();
    check("stall_done", PC, 32'h00400024);

    // Stall while a redirect is in flight
    JumpReg = 1; RegTarget = 32'h00400300;
    step();
    JumpReg = 0; Stall = 1;
    step(); step();
    Stall = 0;
    step(); step();

    // Wrap-around
    jr_to(32'hFFFFFFFC);
    step();
    check("wrap", PC, 32'h00000000);

    // Halt freezes PC even with a jump asserted
    Halt = 1; Jump = 1; JumpTarget = 26'h0000100;
    step();
    Halt = 0;
    check("halted", 32'(Halted), 32'd1);
    step(); step();
    check("halt_pc", PC, 32'h00000000);
    Jump = 0;

    // Reset mid-redirect drops the pending target
    Reset = 1; step(); Reset = 0;
    step(); step();
    JumpReg = 1; RegTarget = 32'h00400400;
    step();
    JumpReg = 0; Reset = 1;
    step();
    check("reset_mid", PC, 32'h00400000);
    Reset = 0;
    step(); step(); step();
    check("after_reset", PC, 32'h00400004);

    // Random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      Reset        = ($urandom_range(99) < 2);
      Halt         = ($urandom_range(99) < 2);
      Stall        = ($urandom_range(99) < 20);
      Branch       = 1'($urandom);
      Zero         = 1'($urandom);
      BranchOffset = 16'($urandom);
      Jump         = ($urandom_range(99) < 15);
      JumpTarget   = 26'($urandom);
      JumpReg      = ($urandom_range(99) < 15);
      RegTarget    = ($urandom_range(9) == 0) ? 32'($urandom) : {30'($urandom), 2'b00};
      startPC      = {30'($urandom), 2'b00};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
